// File: rtl/ff256_mult_vec_wb.sv
// rtl/ff256_mult_vec_wb.sv - Wishbone GF(2^8) vector multiplier with per-lane run-time constants.
// Optional interrupt output and CTRL[3] irq_en enabled by defining FF256_MV_IRQ_EN.
module ff256_mult_vec_wb #(
    parameter int         N_WORDS    = 2,
    parameter int         BUS_WIDTH  = 3,
    parameter int         DATA_WIDTH = 32,
    parameter int         BE_WIDTH   = 4,
    parameter logic [7:0] POLY       = 8'h1B
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [BUS_WIDTH-1:0]  adr_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic                  we_i,
    input  logic [BE_WIDTH-1:0]   sel_i,
    input  logic                  stb_i,
    output logic                  ack_o,
    input  logic                  cyc_i
`ifdef FF256_MV_IRQ_EN
    ,
    output logic                  irq_o
`endif
);
    localparam int LANES    = 4 * N_WORDS;
    localparam int CTRL_ADR = 3 * N_WORDS;

    typedef enum logic {IDLE, RUN} state_t;

    state_t                      state_q, state_d;
    logic [2:0]                  count_q, count_d;
    logic [N_WORDS-1:0][31:0]    a_q, a_d;
    logic [N_WORDS-1:0][31:0]    b_q, b_d;
    logic [N_WORDS-1:0][31:0]    r_q, r_d;
    logic [LANES-1:0][7:0]       acc_q, acc_d;
    logic                        done_q, done_d;
    logic                        ack_q, ack_d;
    logic [31:0]                 data_q, data_d;
`ifdef FF256_MV_IRQ_EN
    logic                        irq_en_q, irq_en_d;
    logic                        irq_q, irq_d;
`endif

    logic [LANES-1:0][7:0]       a_lanes, b_lanes;
    logic                        access, wr, busy, start, ctrl_hit, irq_en_rd;
    logic [31:0]                 adr_ext, rd_val;

    assign a_lanes = a_q;
    assign b_lanes = b_q;

    // One MSB-first Horner step: multiply accumulator by x, reduce, add B if the A bit is set.
    function automatic logic [7:0] gf_step(input logic [7:0] acc, input logic [7:0] b,
                                           input logic abit);
        return {acc[6:0], 1'b0} ^ (acc[7] ? POLY : 8'h00) ^ (abit ? b : 8'h00);
    endfunction

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        acc_d   = acc_q;
        done_d  = done_q;
        data_d  = data_q;
`ifdef FF256_MV_IRQ_EN
        irq_en_d  = irq_en_q;
        irq_en_rd = irq_en_q;
`else
        irq_en_rd = 1'b0;
`endif
        access   = cyc_i & stb_i & ~ack_q;
        wr       = access & we_i;
        busy     = (state_q == RUN);
        adr_ext  = 32'(adr_i);
        ctrl_hit = (adr_ext == 32'(CTRL_ADR));
        start    = wr & ctrl_hit & sel_i[0] & data_i[0] & ~busy;

        rd_val = 32'h0;
        for (int w = 0; w < N_WORDS; w++) begin
            if (adr_ext == 32'(w))             rd_val = a_q[w];
            if (adr_ext == 32'(N_WORDS + w))   rd_val = b_q[w];
            if (adr_ext == 32'(2*N_WORDS + w)) rd_val = r_q[w];
        end
        if (ctrl_hit) rd_val = {28'h0, irq_en_rd, done_q, busy, 1'b0};

        ack_d = access;
        if (access) data_d = rd_val;

        // Operands are frozen while the engine runs.
        if (wr && !busy) begin
            for (int w = 0; w < N_WORDS; w++) begin
                for (int bt = 0; bt < 4; bt++) begin
                    if (sel_i[bt] && adr_ext == 32'(w))
                        a_d[w][8*bt +: 8] = data_i[8*bt +: 8];
                    if (sel_i[bt] && adr_ext == 32'(N_WORDS + w))
                        b_d[w][8*bt +: 8] = data_i[8*bt +: 8];
                end
            end
        end

        if (wr && ctrl_hit && sel_i[0]) begin
            if (data_i[2]) done_d = 1'b0;
`ifdef FF256_MV_IRQ_EN
            irq_en_d = data_i[3];
`endif
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    count_d = 3'd0;
                    acc_d   = '0;
                    done_d  = 1'b0;
                end
            end
            RUN: begin
                for (int k = 0; k < LANES; k++)
                    acc_d[k] = gf_step(acc_q[k], b_lanes[k], a_lanes[k][3'd7 - count_q]);
                count_d = count_q + 3'd1;
                if (count_q == 3'd7) begin
                    r_d     = acc_d;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef FF256_MV_IRQ_EN
        irq_d = done_d & irq_en_d;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= 3'd0;
            a_q      <= '0;
            b_q      <= '0;
            r_q      <= '0;
            acc_q    <= '0;
            done_q   <= 1'b0;
            ack_q    <= 1'b0;
            data_q   <= 32'h0;
`ifdef FF256_MV_IRQ_EN
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            a_q      <= a_d;
            b_q      <= b_d;
            r_q      <= r_d;
            acc_q    <= acc_d;
            done_q   <= done_d;
            ack_q    <= ack_d;
            data_q   <= data_d;
`ifdef FF256_MV_IRQ_EN
            irq_en_q <= irq_en_d;
            irq_q    <= irq_d;
`endif
        end
    end

    assign data_o = data_q;
    assign ack_o  = ack_q;
`ifdef FF256_MV_IRQ_EN
    assign irq_o  = irq_q;
`endif

endmodule

// File: tb/tb_ff256_mult_vec_wb.sv
// tb/tb_ff256_mult_vec_wb.sv - randomized self-checking bench for ff256_mult_vec_wb.
module tb_ff256_mult_vec_wb;
    localparam int N    = 2;
    localparam int BW   = 3;
    localparam int CTRL = 3 * N;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [BW-1:0] adr_i = '0;
    logic [31:0]   data_i = '0;
    logic [31:0]   data_o;
    logic          we_i = 1'b0;
    logic [3:0]    sel_i = '0;
    logic          stb_i = 1'b0;
    logic          ack_o;
    logic          cyc_i = 1'b0;
`ifdef FF256_MV_IRQ_EN
    logic          irq_o;
`endif

    ff256_mult_vec_wb #(.N_WORDS(N), .BUS_WIDTH(BW)) dut (
        .clk(clk), .reset(reset), .adr_i(adr_i), .data_i(data_i), .data_o(data_o),
        .we_i(we_i), .sel_i(sel_i), .stb_i(stb_i), .ack_o(ack_o), .cyc_i(cyc_i)
`ifdef FF256_MV_IRQ_EN
        , .irq_o(irq_o)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc_cnt = 0;
    bit in_reset = 1'b1;
    logic        exp_ack = 1'b0;
    logic [31:0] exp_data = '0;

    logic [31:0] m_a[N], m_b[N], m_r[N], m_pend[N];
    bit m_pending, m_done, m_irq_en;
    int m_done_edge;

    always @(posedge clk) cyc_cnt++;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            y = y >> 1;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1B) : {x[6:0], 1'b0};
        end
        return p;
    endfunction

    function automatic void model_reset();
        for (int w = 0; w < N; w++) begin
            m_a[w] = '0; m_b[w] = '0; m_r[w] = '0; m_pend[w] = '0;
        end
        m_pending = 0; m_done = 0; m_irq_en = 0; m_done_edge = 0;
    endfunction

    // Apply the completion once the edge that finishes the product has passed.
    function automatic void finalize(input int e_after);
        if (m_pending && e_after >= m_done_edge) begin
            for (int w = 0; w < N; w++) m_r[w] = m_pend[w];
            m_done = 1;
            m_pending = 0;
        end
    endfunction

    function automatic logic [31:0] model_read(input int adr);
        if (adr < N)     return m_a[adr];
        if (adr < 2*N)   return m_b[adr-N];
        if (adr < 3*N)   return m_r[adr-2*N];
        if (adr == CTRL) return {28'h0, m_irq_en, m_done, m_pending, 1'b0};
        return 32'h0;
    endfunction

    function automatic void model_access(input logic w, input int adr, input logic [31:0] d,
                                         input logic [3:0] s, input int e);
        bit busy;
        finalize(e - 1);
        busy = m_pending;
        exp_data = model_read(adr);
        exp_ack = 1'b1;
        if (w) begin
            for (int bt = 0; bt < 4; bt++) begin
                if (s[bt] && !busy && adr < N)             m_a[adr][8*bt +: 8] = d[8*bt +: 8];
                if (s[bt] && !busy && adr >= N && adr < 2*N) m_b[adr-N][8*bt +: 8] = d[8*bt +: 8];
            end
            if (adr == CTRL && s[0]) begin
                if (d[2]) m_done = 0;
`ifdef FF256_MV_IRQ_EN
                m_irq_en = d[3];
`endif
                if (d[0] && !busy) begin
                    for (int wd = 0; wd < N; wd++)
                        for (int l = 0; l < 4; l++)
                            m_pend[wd][8*l +: 8] = gf_mul(m_a[wd][8*l +: 8], m_b[wd][8*l +: 8]);
                    m_pending = 1;
                    m_done = 0;
                    m_done_edge = e + 8;
                end
            end
        end
        finalize(e);
    endfunction

    always @(negedge clk) begin
        if (!in_reset) begin
            finalize(cyc_cnt);
            check("ack_o", {31'h0, ack_o}, {31'h0, exp_ack});
            check("data_o", data_o, exp_data);
`ifdef FF256_MV_IRQ_EN
            check("irq_o", {31'h0, irq_o}, {31'h0, m_done & m_irq_en});
`endif
        end
    end

    task automatic bus(input logic w, input int adr, input logic [31:0] d, input logic [3:0] s,
                       output logic [31:0] rd);
        @(negedge clk);
        cyc_i = 1; stb_i = 1; we_i = w; adr_i = adr[BW-1:0]; data_i = d; sel_i = s;
        @(posedge clk); #1;
        model_access(w, adr, d, s, cyc_cnt);
        cyc_i = 0; stb_i = 0; we_i = 0;
        @(negedge clk);
        rd = data_o;
        @(posedge clk); #1;
        exp_ack = 1'b0;
    endtask

    task automatic do_reset();
        in_reset = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
        exp_ack = 1'b0;
        exp_data = '0;
        in_reset = 1'b0;
    endtask

    task automatic wait_done();
        logic [31:0] rd;
        bit seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            bus(0, CTRL, 0, 4'hF, rd);
            seen = rd[2];
        end
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL done_timeout: got done=0 expected done=1");
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        model_reset();
        check("gf 57*83", {24'h0, gf_mul(8'h57, 8'h83)}, 32'hC1);
        check("gf 02*80", {24'h0, gf_mul(8'h02, 8'h80)}, 32'h1B);
        check("gf 57*13", {24'h0, gf_mul(8'h57, 8'h13)}, 32'hFE);
        check("gf FF*01", {24'h0, gf_mul(8'hFF, 8'h01)}, 32'hFF);
        do_reset();

        for (int a = 0; a <= CTRL; a++) begin
            bus(0, a, 0, 4'hF, rd);
            check("reset_read", rd, 32'h0);
        end

        bus(1, 0, 32'h00FF0257, 4'hF, rd);
        bus(1, N, 32'h13018083, 4'hF, rd);
        bus(1, CTRL, 32'h1, 4'hF, rd);
        bus(0, CTRL, 0, 4'hF, rd);
        check("busy_during_run", rd, 32'h2);
        wait_done();
        bus(0, 2*N, 0, 4'hF, rd);
        check("R0_vector", rd, 32'h00FF1BC1);

        bus(1, CTRL, 32'h1, 4'hF, rd);
        bus(1, 0, 32'hFFFFFFFF, 4'hF, rd);
        bus(1, CTRL, 32'h1, 4'hF, rd);
        wait_done();
        bus(0, 0, 0, 4'hF, rd);
        check("A0_frozen", rd, 32'h00FF0257);
        bus(0, 2*N, 0, 4'hF, rd);
        check("R0_repeat", rd, 32'h00FF1BC1);

        bus(1, 0, 32'h0, 4'hF, rd);
        bus(1, 0, 32'hAAAAAAAA, 4'b0010, rd);
        bus(0, 0, 0, 4'hF, rd);
        check("A0_partial", rd, 32'h0000AA00);
        bus(1, CTRL + 1, 32'hFFFFFFFF, 4'hF, rd);
        bus(0, CTRL + 1, 0, 4'hF, rd);
        check("unmapped_read", rd, 32'h0);

        bus(1, 0, 32'h57, 4'hF, rd);
        bus(1, N, 32'h13, 4'hF, rd);
        bus(1, CTRL, 32'h1, 4'hF, rd);
        repeat (3) @(posedge clk);
        do_reset();
        bus(0, CTRL, 0, 4'hF, rd);
        check("ctrl_after_midrun_reset", rd, 32'h0);
        bus(0, 2*N, 0, 4'hF, rd);
        check("R0_after_midrun_reset", rd, 32'h0);
        bus(1, 0, 32'h57, 4'hF, rd);
        bus(1, N, 32'h13, 4'hF, rd);
        bus(1, CTRL, 32'h1, 4'hF, rd);
        wait_done();
        bus(0, 2*N, 0, 4'hF, rd);
        check("R0_57x13", {24'h0, rd[7:0]}, 32'hFE);

`ifdef FF256_MV_IRQ_EN
        bus(1, CTRL, 32'h8, 4'hF, rd);
        bus(1, CTRL, 32'h9, 4'hF, rd);
        wait_done();
        check("irq_high", {31'h0, irq_o}, 32'h1);
        bus(1, CTRL, 32'h4, 4'hF, rd);
        check("irq_cleared", {31'h0, irq_o}, 32'h0);
`endif

        for (int it = 0; it < 16; it++) begin
            for (int w = 0; w < N; w++) begin
                bus(1, w, $urandom, (it % 3 == 0) ? 4'($urandom) : 4'hF, rd);
                bus(1, N + w, $urandom, 4'hF, rd);
            end
            bus(1, CTRL, {28'h0, 1'b0, 1'($urandom), 2'b01}, 4'hF, rd);
            if (it % 2 == 1) bus(1, $urandom_range(0, 2*N-1), $urandom, 4'hF, rd);
            wait_done();
            for (int w = 0; w < N; w++) bus(0, 2*N + w, 0, 4'hF, rd);
            if (it % 4 == 3) bus(1, CTRL, 32'h4, 4'hF, rd);
        end

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
